// File: rtl/serdes_pkg.sv
// serdes_pkg: shared state encoding and counter sizing for the SERDES chain
package serdes_pkg;
  typedef enum logic {IDLE, SEND} ser_state_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/serializer_ctrl.sv
// serializer_ctrl: block-accept / word-emit FSM and word index counter
module serializer_ctrl
  import serdes_pkg::*;
#(
  parameter int N_SAMPLES = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          recv_val,
  input  logic                          send_rdy,
  output logic                          load_en,
  output logic                          send_val,
  output logic                          recv_rdy,
  output logic [cnt_w(N_SAMPLES)-1:0]   cnt
);
  localparam int CNT_W = cnt_w(N_SAMPLES);
  ser_state_t state, state_n;
  logic [CNT_W-1:0] cnt_n;
  logic last, fire, done;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  // Accepting on the last word lets a new block follow with no bubble.
  always_comb begin
    last     = cnt == CNT_W'(N_SAMPLES - 1);
    recv_rdy = !reset && (state == IDLE || (last && send_rdy));
    send_val = !reset && state == SEND;
    load_en  = recv_val && recv_rdy;
    fire     = send_val && send_rdy;
    done     = fire && last;
    state_n  = load_en ? SEND : done ? IDLE : state;
    cnt_n    = (load_en || done) ? '0 : fire ? cnt + 1'b1 : cnt;
  end
endmodule

// File: rtl/serializer.sv
// serializer: latches a block of N_SAMPLES words and emits them one per send handshake
module serializer
  import serdes_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES-1:0],
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic [BIT_WIDTH-1:0] send_msg,
  output logic                 send_val,
  input  logic                 send_rdy
);
  localparam int CNT_W = cnt_w(N_SAMPLES);
  logic [BIT_WIDTH-1:0] blk [N_SAMPLES-1:0];
  logic [CNT_W-1:0] cnt;
  logic load_en;
  serializer_ctrl #(.N_SAMPLES(N_SAMPLES)) ctrl (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .send_rdy (send_rdy),
    .load_en  (load_en),
    .send_val (send_val),
    .recv_rdy (recv_rdy),
    .cnt      (cnt)
  );
  always_ff @(posedge clk) begin
    if (load_en) blk <= recv_msg;
  end
  assign send_msg = blk[cnt];
endmodule

// File: tb/tb_serializer.sv
// tb_serializer: random-data checks of serializer against a word-queue reference model
module tb_serializer;
  localparam int W = 32;
  localparam int N = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic [W-1:0] recv_msg [N-1:0];
  logic recv_val, recv_rdy, send_val, send_rdy;
  logic [W-1:0] send_msg;
  logic [W-1:0] recv_msg2 [1:0];
  logic recv_val2, recv_rdy2, send_val2, send_rdy2;
  logic [W-1:0] send_msg2;
  serializer #(.BIT_WIDTH(W), .N_SAMPLES(N)) dut (
    .clk(clk), .reset(reset), .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy)
  );
  serializer #(.BIT_WIDTH(W), .N_SAMPLES(2)) dut2 (
    .clk(clk), .reset(reset), .recv_msg(recv_msg2), .recv_val(recv_val2), .recv_rdy(recv_rdy2),
    .send_msg(send_msg2), .send_val(send_val2), .send_rdy(send_rdy2)
  );
  int n_cmp = 0, n_err = 0, cyc = 0, mode = 0;
  logic [W-1:0] q [$];
  logic [W-1:0] q2 [$];
  logic [W-1:0] seen2 [$];
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // Model: queue of words still owed downstream; a block can be taken when at most the last word remains and is leaving.
  always @(negedge clk) begin
    logic rdy_e, val_e;
    val_e = !reset && q.size() > 0;
    rdy_e = !reset && (q.size() == 0 || (q.size() == 1 && send_rdy));
    chk("send_val", send_val, val_e);
    chk("recv_rdy", recv_rdy, rdy_e);
    if (val_e) chk("send_msg", send_msg, q[0]);
    if (reset) q = {};
    else begin
      if (val_e && send_rdy) void'(q.pop_front());
      if (rdy_e && recv_val) for (int i = 0; i < N; i++) q.push_back(recv_msg[i]);
    end
  end
  always @(negedge clk) begin
    logic rdy_e, val_e;
    val_e = !reset && q2.size() > 0;
    rdy_e = !reset && (q2.size() == 0 || (q2.size() == 1 && send_rdy2));
    chk("send_val2", send_val2, val_e);
    chk("recv_rdy2", recv_rdy2, rdy_e);
    if (val_e) chk("send_msg2", send_msg2, q2[0]);
    if (reset) q2 = {};
    else begin
      if (val_e && send_rdy2) seen2.push_back(q2.pop_front());
      if (rdy_e && recv_val2) for (int i = 0; i < 2; i++) q2.push_back(recv_msg2[i]);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    send_rdy = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
    if (!recv_val) for (int i = 0; i < N; i++) recv_msg[i] = $urandom;
    #1;
  endtask
  task automatic put(input logic [W-1:0] base, input bit rnd);
    bit r, ok;
    ok = 0;
    for (int i = 0; i < N; i++) recv_msg[i] = rnd ? $urandom : base + W'(i);
    recv_val = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      r = recv_rdy;
      step();
      ok = r;
    end
    if (!ok) chk("put_timeout", 0, 1);
    recv_val = 1'b0;
  endtask
  task automatic drain();
    bit ok;
    ok = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      ok = !send_val && q.size() == 0;
      if (!ok) step();
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask
  initial begin
    reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b0;
    recv_val2 = 1'b0; send_rdy2 = 1'b0;
    for (int i = 0; i < N; i++) recv_msg[i] = '0;
    for (int i = 0; i < 2; i++) recv_msg2[i] = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    mode = 0; put(0, 0); drain();
    put($urandom, 1); put($urandom, 1); drain();
    mode = 1; put(32'h10, 0);
    recv_val = 1'b1;
    repeat (3) begin
      for (int i = 0; i < N; i++) recv_msg[i] = $urandom;
      step();
    end
    recv_val = 1'b0;
    drain();
    mode = 0; put(32'h100, 0);
    repeat (3) step();
    reset = 1'b1; step();
    reset = 1'b0; step();
    put(32'hF0, 0); drain();
    mode = 2;
    for (int k = 0; k < 20; k++) begin
      put($urandom, 1);
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();
    mode = 1;
    for (int k = 0; k < 4; k++) put($urandom, 1);
    drain();
    chk("queue_empty", q.size(), 0);
    recv_msg2[0] = 1; recv_msg2[1] = 2; recv_val2 = 1'b1; send_rdy2 = 1'b1;
    step();
    recv_msg2[0] = 3; recv_msg2[1] = 4;
    step(); step();
    recv_val2 = 1'b0;
    repeat (4) step();
    chk("n2_count", seen2.size(), 4);
    for (int i = 0; i < 4 && i < seen2.size(); i++) chk("n2_stream", seen2[i], W'(i + 1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
